onehot_encoder_sync: RTL and testbench

- Registered 4-to-2 encoder: the encode-side counterpart to the team's 2-to-4 decoder.
- Samples four request lines, debounces them, and priority-encodes the active line into a 2-bit code.
- Presents the code with a valid/ready handshake, then requires all lines to be released before the next code is issued.
- Sits between raw request or button inputs and downstream logic that consumes one code per event.

---
 rtl/onehot_encoder_sync.sv | 192 +++++++++++++++++++
 tb/tb_onehot_encoder_sync.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_sync.sv
// ---------------------------------------------------------------------------
// onehot_encoder_sync
//
// Registered 4-to-2 priority encoder with debounce and a valid/ready
// handshake. It is the encode-side partner of the 2-to-4 decoder. The block
// samples four request lines and waits until they have been nonzero and
// unchanged for DEBOUNCE_CYCLES consecutive clock edges. It then presents the
// index of the highest active line. After the consumer accepts the code, all
// lines must be released before another code can be issued.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive equal nonzero samples needed (1..255)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk    in   1  rising-edge system clock
//   reset  in   1  synchronous, active-high reset
//   in     in   4  request lines, in[3] has highest priority
//   ready  in   1  consumer accepts the code when ready && valid at an edge
//   code   out  2  encoded index of the highest active line
//   valid  out  1  code is stable and awaiting acceptance
//   err    out  1  multi-hot flag (only live when the macro below is defined)
//
// Optional feature
//   ONEHOT_MULTIHOT_ERR_EN : when defined, err is raised together with valid
//   if the debounced sample had more than one bit set. When undefined, err is
//   held at 0 and multi-hot inputs are silently priority-encoded.
//
// Every output comes straight from a flop. No input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module onehot_encoder_sync #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in,
  input  logic       ready,
  output logic [1:0] code,
  output logic       valid,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESENT  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DC_CNT  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sample_q, sample_d;
  logic [1:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] cnt_inc;

  // Highest set bit wins; an all-zero vector maps to 0, but that case is never
  // loaded because only nonzero samples reach the PRESENT load.
  function automatic logic [1:0] prio_enc(input logic [3:0] v);
    logic [1:0] r;
    if (v[3])      r = 2'd3;
    else if (v[2]) r = 2'd2;
    else if (v[1]) r = 2'd1;
    else           r = 2'd0;
    return r;
  endfunction

`ifdef ONEHOT_MULTIHOT_ERR_EN
  // Clearing the lowest set bit leaves something behind only when two or more
  // bits were set.
  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction
`endif

  // The counter saturates instead of wrapping. This keeps a pathological
  // parameter choice from re-arming the debounce after an overflow.
  always_comb begin
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;
  end

  // Next-state logic. All outputs are computed here as *_d values, so the
  // registered copies are the only things that reach the ports.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    code_d   = code_q;
    valid_d  = valid_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (in != 4'd0) begin
          sample_d = in;
          cnt_d    = CNT_ONE;
          if (DEBOUNCE_CYCLES == 1) begin
            // A single agreeing sample is already enough, so the code is
            // loaded on this same edge.
            code_d  = prio_enc(in);
            valid_d = 1'b1;
`ifdef ONEHOT_MULTIHOT_ERR_EN
            err_d   = multi_hot(in);
`else
            err_d   = 1'b0;
`endif
            state_d = PRESENT;
          end else begin
            state_d = DEBOUNCE;
          end
        end
      end

      DEBOUNCE: begin
        if (in == 4'd0) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (in != sample_q) begin
          // A different nonzero pattern restarts the debounce window with the
          // new pattern instead of dropping back to IDLE.
          sample_d = in;
          cnt_d    = CNT_ONE;
        end else if (cnt_inc >= DC_CNT) begin
          code_d  = prio_enc(sample_q);
          valid_d = 1'b1;
`ifdef ONEHOT_MULTIHOT_ERR_EN
          err_d   = multi_hot(sample_q);
`else
          err_d   = 1'b0;
`endif
          cnt_d   = '0;
          state_d = PRESENT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      PRESENT: begin
        // The request lines are ignored while a code waits. The handshake
        // clears the flags, and code keeps its last value.
        if (ready) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        // One code per event: wait here until every line has dropped.
        if (in == 4'd0) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. A synchronous reset overrides everything and
  // aborts any pending code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sample_q <= 4'd0;
      code_q   <= 2'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_onehot_encoder_sync.sv
// ---------------------------------------------------------------------------
// tb_onehot_encoder_sync
//
// Bench for onehot_encoder_sync with DEBOUNCE_CYCLES=4.
//
// The reference model works in terms of events rather than FSM states:
//   - It keeps the run length of identical nonzero samples.
//   - It tracks whether the lines have been released since the last accepted
//     code.
//   - It tracks whether a code is currently on offer.
// Every cycle after the first reset edge, the DUT outputs are compared against
// the model. Directed checkpoints compare both the DUT and the model against
// hand-computed literals.
// ---------------------------------------------------------------------------
module tb_onehot_encoder_sync;

  localparam int DC = 4;
`ifdef ONEHOT_MULTIHOT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] in;
  logic       ready;
  logic [1:0] code;
  logic       valid;
  logic       err;

  int checks   = 0;
  int failures = 0;

  onehot_encoder_sync #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in(in),
    .ready(ready),
    .code(code),
    .valid(valid),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  bit         model_live = 1'b0;
  bit         armed      = 1'b1;
  int         run_len    = 0;
  logic [3:0] run_val    = 4'd0;
  logic       m_valid    = 1'b0;
  logic [1:0] m_code     = 2'd0;
  logic       m_err      = 1'b0;

  // Model update on each rising edge. Inputs change only on falling edges,
  // so the values read here are the ones the DUT samples.
  always @(posedge clk) begin
    if (reset) begin
      model_live = 1'b1;
      armed      = 1'b1;
      run_len    = 0;
      run_val    = 4'd0;
      m_valid    = 1'b0;
      m_code     = 2'd0;
      m_err      = 1'b0;
    end else if (m_valid) begin
      if (ready) begin
        m_valid = 1'b0;
        m_err   = 1'b0;
        armed   = 1'b0;
      end
    end else if (!armed) begin
      if (in == 4'd0) armed = 1'b1;
    end else begin
      if (in == 4'd0) begin
        run_len = 0;
      end else if (in == run_val && run_len > 0) begin
        run_len++;
      end else begin
        run_val = in;
        run_len = 1;
      end
      if (run_len == DC) begin
        run_len = 0;
        m_valid = 1'b1;
        m_code  = 2'd0;
        for (int b = 0; b < 4; b++) if (run_val[b]) m_code = 2'(b);
        m_err   = ERR_EN && ($countones(run_val) > 1);
      end
    end
  end

  // Per-cycle comparison, 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (model_live) begin
      checks++;
      if (valid !== m_valid || code !== m_code || err !== m_err) begin
        failures++;
        $display("[TB] FAIL cycle_compare t=%0t got valid=%b code=%b err=%b required valid=%b code=%b err=%b",
                 $time, valid, code, err, m_valid, m_code, m_err);
      end
    end
  end

  // Hold the given inputs for n rising edges. Returns just after the last one.
  task automatic applyStimulus(input logic [3:0] i, input logic r,
                               input logic rst, input int n);
    repeat (n) begin
      @(negedge clk);
      in    = i;
      ready = r;
      reset = rst;
    end
    @(posedge clk);
    #1;
  endtask

  // Literal checkpoint: compares both the DUT and the model.
  task automatic checkOutput(input string name, input logic ev,
                             input logic [1:0] ec, input logic ee);
    checks++;
    if (valid !== ev || code !== ec || err !== ee) begin
      failures++;
      $display("[TB] FAIL %s dut got valid=%b code=%b err=%b required valid=%b code=%b err=%b",
               name, valid, code, err, ev, ec, ee);
    end
    checks++;
    if (m_valid !== ev || m_code !== ec || m_err !== ee) begin
      failures++;
      $display("[TB] FAIL %s model got valid=%b code=%b err=%b required valid=%b code=%b err=%b",
               name, m_valid, m_code, m_err, ev, ec, ee);
    end
  endtask

  initial begin
    reset = 1'b1;
    in    = 4'd0;
    ready = 1'b0;

    // Reset with a line already held, then debounce it.
    applyStimulus(4'b0100, 1'b0, 1'b1, 2);
    checkOutput("reset_state", 1'b0, 2'b00, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 3);
    checkOutput("latency_edge3", 1'b0, 2'b00, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1);
    checkOutput("latency_edge4", 1'b1, 2'b10, 1'b0);

    // Hold without ready, then accept and check the release requirement.
    applyStimulus(4'b0100, 1'b0, 1'b0, 3);
    checkOutput("hold_no_ready", 1'b1, 2'b10, 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1);
    checkOutput("handshake", 1'b0, 2'b10, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 10);
    checkOutput("no_reissue_held", 1'b0, 2'b10, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1);
    applyStimulus(4'b0100, 1'b0, 1'b0, 4);
    checkOutput("reissue_after_release", 1'b1, 2'b10, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1);

    // Glitch rejection and restart on a changed pattern.
    applyStimulus(4'b0001, 1'b0, 1'b0, 2);
    applyStimulus(4'b0000, 1'b0, 1'b0, 3);
    checkOutput("glitch_dropped", 1'b0, 2'b10, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 2);
    applyStimulus(4'b0010, 1'b0, 1'b0, 3);
    checkOutput("restart_edge5", 1'b0, 2'b10, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1);
    checkOutput("restart_edge6", 1'b1, 2'b01, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1);

    // Multi-hot priority; err follows the build option.
    applyStimulus(4'b1010, 1'b0, 1'b0, 4);
    checkOutput("multihot", 1'b1, 2'b11, ERR_EN);
    applyStimulus(4'b1010, 1'b1, 1'b0, 1);
    checkOutput("multihot_accept", 1'b0, 2'b11, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1);

    // The presented code ignores input changes.
    applyStimulus(4'b0001, 1'b0, 1'b0, 4);
    checkOutput("present_code00", 1'b1, 2'b00, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0, 5);
    checkOutput("present_stable", 1'b1, 2'b00, 1'b0);

    // Reset while presenting; the held line must be debounced again.
    applyStimulus(4'b1000, 1'b0, 1'b1, 1);
    checkOutput("mid_reset", 1'b0, 2'b00, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 3);
    checkOutput("post_reset_edge3", 1'b0, 2'b00, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1);
    checkOutput("post_reset_edge4", 1'b1, 2'b00, 1'b0);

    // ready is ignored outside PRESENT; a held ready accepts on the next edge.
    applyStimulus(4'b0001, 1'b1, 1'b0, 1);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1);
    applyStimulus(4'b0100, 1'b1, 1'b0, 3);
    checkOutput("ready_ignored_debounce", 1'b0, 2'b00, 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1);
    checkOutput("ready_held_present", 1'b1, 2'b10, 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1);
    checkOutput("ready_held_accept", 1'b0, 2'b10, 1'b0);

    applyStimulus(4'b0000, 1'b0, 1'b0, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
